// File: rtl/gray_frame_ctrl.sv
// Frame sequencer: fetches RGB pixels from BRAM, runs them through an ap_ctrl_hs
// grayscale filter and writes each result to the output BRAM.
module gray_frame_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int NUM_PIX = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_r,
  input  logic [7:0]        mem_g,
  input  logic [7:0]        mem_b,
  output logic [7:0]        flt_red,
  output logic [7:0]        flt_green,
  output logic [7:0]        flt_blue,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic [7:0]        ap_return,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic [ADDR_W:0]   pix_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_RUN       = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_WRITE     = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t            state_r, state_next;
  logic              start_go_s, latch_go_s, capture_s, write_go_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W:0]   pix_count_r;
  logic [7:0]        red_r, green_r, blue_r, result_r;
  logic              busy_r, mem_en_r, ap_start_r, we_r, done_r;
  logic              unused_status;

  // ap_idle is status-only and never steers the sequencer
  assign unused_status = ap_idle;

  // Next-state decode; abort overrides every transition
  always_comb begin
    state_next = state_r;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:      state_next = start ? S_FETCH : S_IDLE;
        S_FETCH:     state_next = S_LATCH;
        S_LATCH:     state_next = S_RUN;
        S_RUN: begin
          if (ap_ready && ap_done) begin
            state_next = S_WRITE;
          end else if (ap_ready) begin
            state_next = S_WAIT_DONE;
          end else begin
            state_next = S_RUN;
          end
        end
        S_WAIT_DONE: state_next = ap_done ? S_WRITE : S_WAIT_DONE;
        S_WRITE:     state_next = (mem_addr_r == LAST_ADDR) ? S_FINISH : S_FETCH;
        S_FINISH:    state_next = S_IDLE;
        default:     state_next = S_IDLE;
      endcase
    end
  end

  // Datapath enables for the current cycle
  always_comb begin
    start_go_s = (state_r == S_IDLE) && start && !abort;
    latch_go_s = (state_r == S_LATCH) && !abort;
    capture_s  = !abort && (((state_r == S_RUN) && ap_ready && ap_done) ||
                            ((state_r == S_WAIT_DONE) && ap_done));
    write_go_s = (state_r == S_WRITE) && !abort;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Address, pixel counter, filter operands and captured result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_r  <= '0;
      pix_count_r <= '0;
      red_r       <= 8'd0;
      green_r     <= 8'd0;
      blue_r      <= 8'd0;
      result_r    <= 8'd0;
    end else begin
      if (start_go_s) begin
        mem_addr_r  <= '0;
        pix_count_r <= '0;
      end else if (write_go_s) begin
        pix_count_r <= pix_count_r + (ADDR_W+1)'(1);
        // Address saturates on the last pixel so it never leaves the frame
        if (mem_addr_r != LAST_ADDR) begin
          mem_addr_r <= mem_addr_r + ADDR_W'(1);
        end
      end
      if (latch_go_s) begin
        red_r   <= mem_r;
        green_r <= mem_g;
        blue_r  <= mem_b;
      end
      if (capture_s) begin
        result_r <= ap_return;
      end
    end
  end

  // Control outputs registered from the next state so they track it exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r     <= 1'b0;
      mem_en_r   <= 1'b0;
      ap_start_r <= 1'b0;
      we_r       <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r     <= (state_next != S_IDLE);
      mem_en_r   <= (state_next == S_FETCH);
      ap_start_r <= (state_next == S_RUN);
      we_r       <= (state_next == S_WRITE);
      done_r     <= (state_next == S_FINISH);
    end
  end

  assign busy       = busy_r;
  assign mem_en     = mem_en_r;
  assign ap_start   = ap_start_r;
  // A same-cycle abort cancels the pending write or completion pulse
  assign out_we     = we_r & ~abort;
  assign frame_done = done_r & ~abort;
  assign mem_addr   = mem_addr_r;
  assign out_addr   = mem_addr_r;
  assign out_data   = result_r;
  assign pix_count  = pix_count_r;
  assign flt_red    = red_r;
  assign flt_green  = green_r;
  assign flt_blue   = blue_r;

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Directed bench for gray_frame_ctrl: a 4-pixel instance with a configurable
// filter model and a 256-pixel instance with a zero-latency filter.
module tb_gray_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, b_start;
  always #5 clk = ~clk;

  // 4-pixel instance
  logic       busy, frame_done, mem_en, ap_start, out_we;
  logic [1:0] mem_addr, out_addr;
  logic [7:0] mem_r, mem_g, mem_b, flt_red, flt_green, flt_blue, out_data;
  logic       ap_ready, ap_done;
  logic [7:0] ap_return;
  logic [2:0] pix_count;

  // 256-pixel instance
  logic       b_busy, b_frame_done, b_mem_en, b_ap_start, b_out_we;
  logic [8:0] b_mem_addr, b_out_addr;
  logic [7:0] b_flt_red, b_flt_green, b_flt_blue, b_out_data, b_ap_return;
  logic [9:0] b_pix_count;

  gray_frame_ctrl #(.ADDR_W(2), .NUM_PIX(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .frame_done(frame_done), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_r(mem_r), .mem_g(mem_g), .mem_b(mem_b),
    .flt_red(flt_red), .flt_green(flt_green), .flt_blue(flt_blue),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(1'b1),
    .ap_return(ap_return), .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .pix_count(pix_count));

  gray_frame_ctrl dut_big (
    .clk(clk), .reset(reset), .start(b_start), .abort(1'b0),
    .busy(b_busy), .frame_done(b_frame_done), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
    .mem_r(8'd30), .mem_g(8'd60), .mem_b(8'd90),
    .flt_red(b_flt_red), .flt_green(b_flt_green), .flt_blue(b_flt_blue),
    .ap_start(b_ap_start), .ap_ready(b_ap_start), .ap_done(b_ap_start), .ap_idle(1'b0),
    .ap_return(b_ap_return), .out_we(b_out_we), .out_addr(b_out_addr), .out_data(b_out_data),
    .pix_count(b_pix_count));

  function automatic logic [7:0] gray(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int t;
    t = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
    return 8'(t >> 8);
  endfunction

  assign b_ap_return = gray(b_flt_red, b_flt_green, b_flt_blue);

  // Pixel image and per-pixel filter timing for the small instance
  logic [7:0] img_r[4], img_g[4], img_b[4];
  int         rdly_tab[4], lat_tab[4];

  // Read BRAM model: data one cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      mem_r <= img_r[mem_addr];
      mem_g <= img_g[mem_addr];
      mem_b <= img_b[mem_addr];
    end
  end

  // Filter model: ap_ready after rdly extra RUN cycles, ap_done lat cycles later
  int         f_cnt, f_rcnt;
  bit         f_busy;
  logic [7:0] f_res;
  always @(negedge clk) begin
    if (!busy) begin
      f_busy = 1'b0; f_rcnt = 0; ap_ready = 1'b0; ap_done = 1'b0; ap_return = 8'd0;
    end else if (f_busy) begin
      ap_ready = 1'b0;
      f_cnt = f_cnt - 1;
      if (f_cnt == 0) begin
        ap_done = 1'b1; ap_return = f_res; f_busy = 1'b0;
      end else begin
        ap_done = 1'b0;
      end
    end else if (ap_start) begin
      if (f_rcnt < rdly_tab[mem_addr]) begin
        f_rcnt = f_rcnt + 1; ap_ready = 1'b0; ap_done = 1'b0;
      end else begin
        f_rcnt = 0; ap_ready = 1'b1;
        f_res = gray(flt_red, flt_green, flt_blue);
        if (lat_tab[mem_addr] == 0) begin
          ap_done = 1'b1; ap_return = f_res;
        end else begin
          ap_done = 1'b0; f_busy = 1'b1; f_cnt = lat_tab[mem_addr];
        end
      end
    end else begin
      ap_ready = 1'b0; ap_done = 1'b0;
    end
  end

  // Output monitor, sampled on the falling edge
  int cyc, wr_n, fd_n, en_n, bad_start_n;
  int wr_addr[64], wr_data[64], wr_cyc[64];
  int b_wr_n, b_fd_n, b_en_n, b_bad, b_max_addr, b_last_addr;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (out_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = int'(out_addr); wr_data[wr_n] = int'(out_data); wr_cyc[wr_n] = cyc;
      end
      wr_n = wr_n + 1;
      if (ap_start) bad_start_n = bad_start_n + 1;
    end
    if (frame_done) fd_n = fd_n + 1;
    if (mem_en) en_n = en_n + 1;
    if (b_out_we) begin
      b_wr_n = b_wr_n + 1; b_last_addr = int'(b_out_addr);
      if (b_out_data != 8'd54) b_bad = b_bad + 1;
    end
    if (b_frame_done) b_fd_n = b_fd_n + 1;
    if (b_mem_en) b_en_n = b_en_n + 1;
    if (int'(b_mem_addr) > b_max_addr) b_max_addr = int'(b_mem_addr);
  end

  typedef struct {
    logic [7:0] r, g, b;
    int         rdly, lat;
    logic [7:0] exp_data;
    int         exp_gap;
  } vec_t;
  vec_t vecs[8];

  int n_chk, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("frame_timeout", 64'(ok), 64'd1);
  endtask

  task automatic set_timing(input int l0, input int l1, input int l2, input int l3);
    lat_tab[0] = l0; lat_tab[1] = l1; lat_tab[2] = l2; lat_tab[3] = l3;
    for (int i = 0; i < 4; i++) rdly_tab[i] = 0;
  endtask

  task automatic run_frame(input int f, input bit mid_pulse);
    int wb, fb, eb;
    for (int i = 0; i < 4; i++) begin
      img_r[i] = vecs[f*4+i].r; img_g[i] = vecs[f*4+i].g; img_b[i] = vecs[f*4+i].b;
      rdly_tab[i] = vecs[f*4+i].rdly; lat_tab[i] = vecs[f*4+i].lat;
    end
    wb = wr_n; fb = fd_n; eb = en_n;
    pulse_start();
    if (mid_pulse) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_idle(300);
    chk("write_count", 64'(wr_n - wb), 64'd4);
    chk("frame_done_count", 64'(fd_n - fb), 64'd1);
    chk("mem_en_count", 64'(en_n - eb), 64'd4);
    chk("pix_count_end", 64'(pix_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("out_addr", 64'(wr_addr[wb+i]), 64'(i));
      chk("out_data", 64'(wr_data[wb+i]), 64'(vecs[f*4+i].exp_data));
      if (i > 0) chk("pixel_gap", 64'(wr_cyc[wb+i] - wr_cyc[wb+i-1]), 64'(vecs[f*4+i].exp_gap));
    end
    repeat (4) @(posedge clk);
    #1 chk("stays_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int wb, fb;
    bit found;
    // r, g, b, ready delay, done latency, expected gray, expected cycles since previous write
    for (int i = 0; i < 4; i++) vecs[i] = '{8'd30, 8'd60, 8'd90, 0, 3, 8'd54, 7};
    vecs[4] = '{8'd255, 8'd255, 8'd255, 0, 0, 8'd255, 0};
    vecs[5] = '{8'd0,   8'd0,   8'd0,   0, 1, 8'd0,   5};
    vecs[6] = '{8'd100, 8'd0,   8'd0,   2, 2, 8'd30,  8};
    vecs[7] = '{8'd0,   8'd200, 8'd10,  0, 0, 8'd118, 4};

    reset = 1'b0; start = 1'b0; abort = 1'b0; b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      img_r[i] = 8'd0; img_g[i] = 8'd0; img_b[i] = 8'd0; rdly_tab[i] = 0; lat_tab[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {busy, frame_done, mem_en, mem_addr, flt_red, flt_green, flt_blue,
                             ap_start, out_we, out_addr, out_data, pix_count}, 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 chk("idle_after_reset", {busy, mem_en, ap_start, out_we}, 64'd0);

    // Uniform frame, then mixed timings with a start pulse while busy
    run_frame(0, 1'b0);
    run_frame(1, 1'b1);

    // start with abort in IDLE stays idle
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'd0);
    @(posedge clk); #1 chk("start_abort_idle2", {busy, mem_en}, 64'd0);

    // Abort while waiting for ap_done on the third pixel
    set_timing(1, 1, 10, 1);
    wb = wr_n; fb = fd_n; found = 1'b0;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      if (mem_addr == 2'd2 && ap_start) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("reach_pixel2_run", 64'(found), 64'd1);
    @(posedge clk); #1 chk("in_wait_done", {busy, ap_start}, 64'b10);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_wait_idle", {busy, ap_start}, 64'd0);
    chk("abort_wait_pix", 64'(pix_count), 64'd2);
    repeat (12) @(posedge clk);
    #1 chk("abort_wait_writes", 64'(wr_n - wb), 64'd2);
    chk("abort_wait_no_done", 64'(fd_n - fb), 64'd0);

    // Abort coincident with the second pixel's write
    set_timing(1, 1, 1, 1);
    wb = wr_n; fb = fd_n; found = 1'b0;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      if (mem_addr == 2'd1 && ap_done) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("reach_pixel1_write", 64'(found), 64'd1);
    abort = 1'b1;
    #1 chk("abort_write_we", 64'(out_we), 64'd0);
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_write_idle", 64'(busy), 64'd0);
    chk("abort_write_pix", 64'(pix_count), 64'd1);
    repeat (5) @(posedge clk);
    #1 chk("abort_write_writes", 64'(wr_n - wb), 64'd1);
    chk("abort_write_no_done", 64'(fd_n - fb), 64'd0);

    // Asynchronous reset during RUN
    set_timing(3, 3, 3, 3);
    wb = wr_n; found = 1'b0;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      if (ap_start) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("reach_run", 64'(found), 64'd1);
    #2 reset = 1'b0;
    #1 chk("async_reset_ctrl", {ap_start, busy, mem_en}, 64'd0);
    chk("async_reset_pix", 64'(pix_count), 64'd0);
    #3 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("no_resume_busy", 64'(busy), 64'd0);
    chk("no_resume_writes", 64'(wr_n - wb), 64'd0);

    // Full 256-pixel frame on the default-size instance
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      if (!b_busy) begin found = 1'b1; break; end
    end
    chk("big_timeout", 64'(found), 64'd1);
    chk("big_writes", 64'(b_wr_n), 64'd256);
    chk("big_last_addr", 64'(b_last_addr), 64'd255);
    chk("big_pix_count", 64'(b_pix_count), 64'd256);
    chk("big_frame_done", 64'(b_fd_n), 64'd1);
    chk("big_mem_en", 64'(b_en_n), 64'd256);
    chk("big_data_errors", 64'(b_bad), 64'd0);
    chk("big_max_mem_addr", 64'(b_max_addr), 64'd255);

    chk("ap_start_during_write", 64'(bad_start_n), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_frame_ctrl.md
GRAY_FRAME_CTRL -- requirements
Module: gray_frame_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, pixel address width.
REQ-002 SHALL have parameter NUM_PIX, default 256, pixels per frame; legal range 1..2**ADDR_W.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port start  in  1  frame start request, sampled in IDLE only.
REQ-006 SHALL have port abort  in  1  synchronous frame abort.
REQ-007 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-008 SHALL have port frame_done  out  1  one-cycle pulse after last pixel written.
REQ-009 SHALL have port mem_en  out  1  read enable to the R/G/B pixel BRAMs.
REQ-010 SHALL have port mem_addr  out  ADDR_W  shared read address to the R/G/B BRAMs.
REQ-011 SHALL have ports mem_r, mem_g, mem_b  in  8 each  BRAM read data, valid 1 cycle after mem_en.
REQ-012 SHALL have ports flt_red, flt_green, flt_blue  out  8 each  registered operands to the filter.
REQ-013 SHALL have port ap_start  out  1  filter start (ap_ctrl_hs).
REQ-014 SHALL have ports ap_ready, ap_done, ap_idle  in  1 each  filter handshake status.
REQ-015 SHALL have port ap_return  in  8  filter grayscale result.
REQ-016 SHALL have ports out_we  out  1, out_addr  out  ADDR_W, out_data  out  8  result BRAM write port.
REQ-017 SHALL have port pix_count  out  ADDR_W+1  pixels written in current/last frame.

Function
REQ-018 SHALL implement states IDLE, FETCH, LATCH, RUN, WAIT_DONE, WRITE, FINISH.
REQ-019 IDLE: start=1 SHALL clear mem_addr and pix_count and go to FETCH; start ignored in all other states.
REQ-020 FETCH: mem_en SHALL be 1 for exactly this cycle; next state LATCH.
REQ-021 LATCH: mem_r/g/b SHALL be registered into flt_red/green/blue; next state RUN.
REQ-022 flt_red/green/blue SHALL remain constant from RUN through WRITE.
REQ-023 RUN: ap_start SHALL be 1; remain in RUN until ap_ready=1, then ap_start SHALL be 0 from the next cycle.
REQ-024 RUN with ap_ready=1 and ap_done=1 in the same cycle SHALL capture ap_return and go directly to WRITE.
REQ-025 RUN with ap_ready=1, ap_done=0 SHALL go to WAIT_DONE; WAIT_DONE SHALL capture ap_return on ap_done=1 and go to WRITE.
REQ-026 ap_done SHALL be ignored outside RUN/WAIT_DONE; ap_idle is status-only and SHALL NOT affect transitions.
REQ-027 WRITE: out_we=1 for one cycle, out_addr=mem_addr, out_data=captured ap_return; pix_count SHALL increment by 1.
REQ-028 WRITE with mem_addr==NUM_PIX-1 SHALL go to FINISH; otherwise mem_addr SHALL increment by 1 and state SHALL go to FETCH.
REQ-029 mem_addr SHALL never exceed NUM_PIX-1; no wrap within a frame.
REQ-030 FINISH: frame_done=1 for one cycle, then IDLE; pix_count SHALL hold NUM_PIX until next start.
REQ-031 Per-pixel latency SHALL be 4 cycles + filter latency (FETCH, LATCH, RUN>=1, WRITE).
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with ap_start=0, no out_we, no frame_done; pix_count holds.
REQ-033 abort coincident with WRITE SHALL suppress that write (abort has priority).
REQ-034 abort in IDLE SHALL have no effect; start and abort both 1 in IDLE SHALL stay in IDLE.

Reset
REQ-035 reset=0 SHALL immediately force IDLE and clear all outputs and registers to 0, independent of clk.
REQ-036 Reset release mid-frame SHALL restart only on a new start; no partial writes resumed.

Verification
REQ-037 NUM_PIX=4, RGB=(30,60,90) each address, filter 3-cycle done -> 4 out_we pulses, addr 0..3, frame_done once, pix_count=4.
REQ-038 Filter asserts ap_ready and ap_done same cycle -> WRITE next cycle, no WAIT_DONE visit, ap_start deasserted.
REQ-039 abort in WAIT_DONE at pixel 2 -> IDLE next cycle, no out_we, no frame_done, pix_count=2.
REQ-040 reset=0 asynchronously during RUN -> ap_start, busy, mem_en drop to 0 before next clk edge.
REQ-041 NUM_PIX=256, ADDR_W=9 -> last write at out_addr=255, pix_count=256, mem_addr never 256.
REQ-042 start pulsed while busy -> ignored; frame completes with exactly NUM_PIX writes.
